// File: rtl/heston_pkg.sv
// Shared Q8.24 constants and the FSM state type used by the Heston pricer blocks.
package heston_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} pm_state_t;

  localparam int                 Q824_FRAC = 24;
  localparam logic signed [31:0] Q824_ONE  = 32'sh01000000;
  localparam logic signed [31:0] Q824_MAX  = 32'sh7FFFFFFF;
  localparam logic signed [31:0] Q824_MIN  = 32'sh80000000;
endpackage

// File: rtl/div_q824.sv
// Combinational signed Q8.24 divide q = a/b, truncating toward zero, clamped to Q8.24 range.
module div_q824
  import heston_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic        [31:0] b,
  output logic signed [31:0] q
);
  logic signed [55:0] num, den, quo;

  assign num = {a, 24'b0};
  assign den = $signed({24'b0, b});

  always_comb begin
    quo = '0;
    q   = '0;
    if (b != '0) begin
      quo = num / den;
      if (quo > 56'(Q824_MAX))      q = Q824_MAX;
      else if (quo < 56'(Q824_MIN)) q = Q824_MIN;
      else                          q = quo[31:0];
    end
  end
endmodule

// File: rtl/payoff_mean_q824.sv
// Monte-Carlo batch averager: exact wide accumulation of Q8.24 payoffs, then sum/N via div_q824.
// Optional PAYOFF_MEAN_SAT_EN clamps the pre-scaled numerator to 32 bits and reports ovf.
module payoff_mean_q824
  import heston_pkg::*;
#(
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 17,
  parameter int NSHIFT = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_paths,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [31:0]      in_payoff,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [31:0]      mean,
  output logic                    err,
  output logic                    ovf,
  output logic                    busy
);
  pm_state_t                st;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt, np, cnt_nx;
  logic signed [ACC_W-1:0]  sh;
  logic signed [31:0]       div_a, div_q;
  logic [31:0]              div_b;
  logic                     sat_hit;
  logic                     unused_hi;

  assign cnt_nx    = cnt + CNT_W'(1);
  assign sh        = acc >>> NSHIFT;
  assign unused_hi = ^sh[ACC_W-1:32];
  assign div_b     = 32'(np) << (Q824_FRAC - NSHIFT);

`ifdef PAYOFF_MEAN_SAT_EN
  always_comb begin
    sat_hit = 1'b1;
    if (sh > ACC_W'(Q824_MAX))      div_a = Q824_MAX;
    else if (sh < ACC_W'(Q824_MIN)) div_a = Q824_MIN;
    else begin
      div_a   = sh[31:0];
      sat_hit = 1'b0;
    end
  end
`else
  // Large sums wrap: only the low 32 bits of the scaled sum reach the divider.
  assign div_a   = sh[31:0];
  assign sat_hit = 1'b0;
`endif

  div_q824 u_div (.a(div_a), .b(div_b), .q(div_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      np        <= '0;
      mean      <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        IDLE: if (start) begin
          acc  <= '0;
          cnt  <= '0;
          np   <= n_paths;
          mean <= '0;
          ovf  <= 1'b0;
          busy <= 1'b1;
          if (n_paths == '0) begin
            st        <= OUT;
            err       <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            st       <= ACCUM;
            err      <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        ACCUM: if (in_valid && in_ready) begin
          acc <= acc + ACC_W'(in_payoff);
          cnt <= cnt_nx;
          if (cnt_nx == np) begin
            st       <= DIV;
            in_ready <= 1'b0;
          end
        end
        DIV: begin
          mean      <= div_q;
          ovf       <= sat_hit;
          st        <= OUT;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          st        <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_payoff_mean_q824.sv
// Directed bench for payoff_mean_q824: stimulus pushes expected results, a monitor pops on handshake.
module tb_payoff_mean_q824;
  logic               clk = 1'b0;
  logic               rst, start, in_valid, in_ready, out_valid, out_ready, err, ovf, busy;
  logic [16:0]        n_paths;
  logic signed [31:0] in_payoff, mean;

  typedef struct packed { logic [31:0] mean; logic err; logic ovf; } exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  payoff_mean_q824 dut (
    .clk(clk), .rst(rst), .start(start), .n_paths(n_paths),
    .in_valid(in_valid), .in_ready(in_ready), .in_payoff(in_payoff),
    .out_valid(out_valid), .out_ready(out_ready), .mean(mean),
    .err(err), .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: a result is consumed whenever valid and ready are both seen high.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got mean %h err %b with no pending expectation", mean, err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (mean !== e.mean || err !== e.err || ovf !== e.ovf) begin
            errors++;
            $display("FAIL result: got mean=%h err=%b ovf=%b expected mean=%h err=%b ovf=%b",
                     mean, err, ovf, e.mean, e.err, e.ovf);
          end
        end
      end
    end
  end

  task automatic start_batch(input int n);
    start = 1'b1; n_paths = 17'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] p, input int gap);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_payoff = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_paths = '0; in_valid = 1'b0; in_payoff = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outs", {25'b0, in_ready, out_valid, busy, err, ovf, 2'b0}, 32'd0);
    chk("reset_mean", mean, 32'd0);

    // Mean of four payoffs, with latency checks.
    start_batch(4);
    chk("accum_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{32'h02800000, 1'b0, 1'b0});
    send(32'h01000000, 0); send(32'h02000000, 0); send(32'h03000000, 0); send(32'h04000000, 0);
    chk("div_cycle_no_valid", {30'b0, out_valid, in_ready}, 32'd0);
    @(negedge clk);
    chk("valid_at_last_plus2", 32'(out_valid), 32'd1);
    wait_idle("four");

    // Signed inputs.
    start_batch(2);
    exp_q.push_back('{32'hFF800000, 1'b0, 1'b0});
    send(32'hFE800000, 0); send(32'h00800000, 0);
    wait_idle("signed");

    // Stalls on input, backpressure on output, start during handshake ignored.
    start_batch(3);
    out_ready = 1'b0;
    exp_q.push_back('{32'h02000000, 1'b0, 1'b0});
    send(32'h01000000, 2); send(32'h02000000, 0); send(32'h03000000, 3);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_mean", mean, 32'h02000000);
    end
    out_ready = 1'b1; start = 1'b1; n_paths = 17'd1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_handshake", {30'b0, busy, out_valid}, 32'd0);

    // Zero-size batch.
    start_batch(0);
    exp_q.push_back('{32'h00000000, 1'b1, 1'b0});
    chk("zero_valid_err", {30'b0, out_valid, err}, 32'd3);
    wait_idle("zero");

    // Saturation / wrap of the scaled numerator.
    start_batch(2048);
`ifdef PAYOFF_MEAN_SAT_EN
    exp_q.push_back('{32'h3FFFFFFF, 1'b0, 1'b1});
`else
    exp_q.push_back('{32'hFFFFFFFF, 1'b0, 1'b0});
`endif
    for (int i = 0; i < 2048; i++) send(32'h7FFFFFFF, 0);
    wait_idle("sat");

    // Reset mid-batch, then a fresh batch.
    start_batch(4);
    send(32'h01000000, 0); send(32'h01000000, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outs", {27'b0, in_ready, out_valid, busy, err, ovf}, 32'd0);
    chk("midrst_mean", mean, 32'd0);
    start_batch(2);
    exp_q.push_back('{32'h01000000, 1'b0, 1'b0});
    send(32'h01000000, 0); send(32'h01000000, 0);
    wait_idle("fresh");

    repeat (3) @(negedge clk);
    chk("pending_results", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/payoff_mean_q824.md
# payoff_mean_q824

Batch averager that accepts a stream of per-path discounted payoffs in Q8.24, accumulates them exactly in a wide register, and forms the Monte-Carlo price estimate sum/N by driving an internal `div_q824` instance. It sits between the path-payoff stage and the result/host interface of the Heston pricer, and is the sole producer of operands for the Q8.24 divider.

## Interface
- Parameters:
  - `ACC_W`, default 48: accumulator width; signed Q24.24.
  - `CNT_W`, default 17: path-count width; covers 1..65536.
  - `NSHIFT`, default 10: operand pre-scale shift.
- Ports (synchronous active-high reset):
  - `clk` in 1: single clock, rising edge.
  - `rst` in 1: synchronous, active-high reset.
  - `start` in 1: begin a batch. Sampled only in IDLE.
  - `n_paths` in CNT_W: batch size. Latched on `start`.
  - `in_valid` in 1: payoff sample valid.
  - `in_ready` out 1: high only in ACCUM.
  - `in_payoff` in 32: signed Q8.24 payoff.
  - `out_valid` out 1: mean available.
  - `out_ready` in 1: consumer accepts the mean.
  - `mean` out 32: signed Q8.24 sum/N.
  - `err` out 1: batch started with `n_paths`=0. Valid with `out_valid`.
  - `ovf` out 1: numerator saturated. Valid with `out_valid`.
  - `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, DIV, OUT.
- IDLE
  - On `start`: clear `acc` and `cnt`, latch `n_paths`.
  - If `n_paths`==0: go to OUT with `mean`=0 and `err`=1.
  - Otherwise go to ACCUM.
- ACCUM
  - A sample is accepted when `in_valid` and `in_ready` are both high.
  - On accept: `acc` += sign-extended `in_payoff`; `cnt`++.
  - The accept that makes `cnt` equal `n_paths` moves the FSM to DIV.
  - The accumulator cannot overflow: 65536 × (2^31−1) < 2^47.
- DIV
  - Divider numerator `a` = `acc` >>> NSHIFT, narrowed to 32 bits (see Configuration).
  - Divider denominator `b` = `n_paths` << (24 − NSHIFT). This is positive and < 2^31 for all legal `n_paths`.
  - Real value of the quotient a/b = sum/N.
  - Register `div_q824.q` into `mean` and go to OUT.
  - The divider is combinational. Its operands come only from registers, so there is no path from input to output.
- OUT
  - `out_valid`=1. `mean`, `err` and `ovf` are held stable.
  - On `out_ready`, go to IDLE.
- `start` is ignored outside IDLE.
- `in_payoff` is ignored outside ACCUM; `in_ready`=0 there.
- Precision: the NSHIFT truncation loses the low 10 LSBs of the sum. The divider then truncates. Acceptance tolerance against the real-valued mean is 2 + 2^NSHIFT/N LSB.

## Timing
- Reset values of outputs:
  - `in_ready`, `out_valid`, `busy`, `err`, `ovf`: 0.
  - `mean`: 0.
  - FSM: IDLE.
- `start` at edge t: `in_ready`=1 from t+1. For `n_paths`=0, `out_valid`=1 from t+1 instead.
- Last sample accepted at edge t: DIV occupies cycle t+1; `out_valid`=1 from t+2.
- Throughput: one sample per cycle with no bubbles while `in_valid` is held high.
- Backpressure: `out_valid` stays high and the outputs stay frozen until `out_ready`.
- Back-to-back batches:
  - `start` is taken only in IDLE, so it is accepted no earlier than the cycle after the OUT handshake.
  - A `start` asserted during the OUT handshake cycle is ignored.
- Reset mid-batch: `rst` has priority over every other event. It discards `acc` and `cnt`, and all outputs take their reset values on the next edge.

## Configuration
- `PAYOFF_MEAN_SAT_EN` defined:
  - `acc` >>> NSHIFT is clamped to the range [0x80000000, 0x7FFFFFFF].
  - `ovf` is set when clamping occurs. It is cleared on `start`.
- `PAYOFF_MEAN_SAT_EN` not defined:
  - The low 32 bits are taken, so large sums wrap.
  - `ovf` is tied to 0.

## Structure
- Shared package `heston_pkg` holds:
  - the FSM state enum;
  - `Q824_FRAC`=24;
  - `Q824_ONE`=32'h01000000;
  - the Q8.24 signed min/max constants.
- One sub-module: `div_q824`, instantiated unchanged. Its port `a` is the numerator, `b` the denominator, and `q` the quotient.

## Test plan
- Mean of four payoffs:
  - Stimulus: `n_paths`=4; payoffs 1.0, 2.0, 3.0, 4.0 (0x01000000..0x04000000).
  - Response: `mean`=0x02800000 (2.5); `err`=0; `ovf`=0; `out_valid` at last-accept + 2.
- Signed inputs:
  - Stimulus: `n_paths`=2; payoffs −1.5 (0xFE800000) and 0.5.
  - Response: `mean`=0xFF800000 (−0.5).
- Stalls and backpressure:
  - Stimulus: `n_paths`=3 with random `in_valid` gaps; `out_ready` held low for 5 cycles.
  - Response: `mean`=correct value held stable with `out_valid` high for all 5 cycles; `busy` drops the cycle after the handshake.
- Zero-size batch:
  - Stimulus: `n_paths`=0.
  - Response: `out_valid` one cycle after `start`; `err`=1; `mean`=0.
- Saturation:
  - Stimulus: `n_paths`=2048; all payoffs 0x7FFFFFFF.
  - Response with the macro: `ovf`=1, `mean`=0x3FFFFFFF.
  - Response without the macro: `ovf`=0, `mean` equals the wrapped-value quotient.
- Reset mid-batch:
  - Stimulus: `rst` pulsed after 2 of 4 samples, then a fresh batch of 1.0, 1.0.
  - Response: all outputs 0 after `rst`; the new batch gives `mean`=0x01000000.
